alu_cmd_sequencer: RTL

- Executes 12-bit register-to-register commands against an external ALU, one at a time.
- Owns the 8x32 register file; decodes opcode, source and destination addresses; reads operands; launches the ALU; waits for completion; writes the result back.
- Replaces the bare edge-triggered issue path; sits between the command source (host or testbench) and the ALU.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_sequencer_if.sv | 22 ++
 rtl/seq_regfile.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, command layout and sequencer state encoding
package alu_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int OP_W     = 3;
    localparam int CMD_W    = 12;
    localparam int TIMEOUT  = 15;

    localparam int OP_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int RD_LSB  = 0;

    // Only HALT is meaningful here; every other code goes to the ALU untouched.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef struct packed {
        opcode_t           op;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, HALT} seq_state_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command handshake plus ALU launch/result bus
interface alu_cmd_sequencer_if;
    logic                       cmd_valid;
    logic [alu_pkg::CMD_W-1:0]  cmd;
    logic                       cmd_ready;
    logic [alu_pkg::OP_W-1:0]   alu_op;
    logic [alu_pkg::DATA_W-1:0] alu_a;
    logic [alu_pkg::DATA_W-1:0] alu_b;
    logic                       alu_start;
    logic                       alu_done;
    logic [alu_pkg::DATA_W-1:0] alu_result;

    modport master (
        input  cmd_valid, cmd, alu_done, alu_result,
        output cmd_ready, alu_op, alu_a, alu_b, alu_start
    );

    modport slave (
        output cmd_valid, cmd, alu_done, alu_result,
        input  cmd_ready, alu_op, alu_a, alu_b, alu_start
    );
endinterface

// File: rtl/seq_regfile.sv
// seq_regfile: 8x32 register file, one write port, three combinational reads
module seq_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] rad,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rdd
);
    logic [DATA_W-1:0] mem [NUM_REGS];

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rdd = mem[rad];

    // Storage: cleared on reset, single write per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: runs register-to-register commands on an external ALU, one at a time
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.master bus,
    output logic                busy,
    output logic                halted,
    output logic                err_timeout,
    input  logic [ADDR_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    seq_state_t        state, state_nxt;
    cmd_t              c;
    logic [DATA_W-1:0] rd1, rd2, res_q;
    logic [ADDR_W-1:0] rd_q;
    logic [3:0]        cnt;
    logic              accept, timeout, we;

    assign c       = cmd_t'(bus.cmd);
    assign accept  = bus.cmd_valid && state == IDLE;
    assign timeout = cnt == CNT_LAST;

    seq_regfile u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (rd_q),
        .wdata (res_q),
        .ra1   (c.rs1),
        .ra2   (c.rs2),
        .rad   (dbg_raddr),
        .rd1   (rd1),
        .rd2   (rd2),
        .rdd   (dbg_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: done is only honoured in WAIT, and WAIT gives up after TIMEOUT cycles
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = c.op == OP_HALT ? HALT : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = bus.alu_done ? WRITE : timeout ? IDLE : WAIT;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = state;
        endcase
    end

    // Outputs decoded from state alone so cmd_ready never depends on cmd_valid
    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.alu_start = state == ISSUE;
        busy          = state != IDLE;
        halted        = state == HALT;
        we            = state == WRITE;
    end

    // Datapath: operand latch on accept, wait counter, result capture, sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_op  <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (accept && c.op != OP_HALT) begin
                bus.alu_a  <= rd1;
                bus.alu_b  <= rd2;
                bus.alu_op <= c.op;
                rd_q       <= c.rd;
            end
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 4'd1;
            if (state == WAIT && bus.alu_done) res_q <= bus.alu_result;
            if (state == WAIT && !bus.alu_done && timeout) err_timeout <= 1'b1;
        end
    end
endmodule
